// File: rtl/irq_ack_sequencer_pkg.sv
// Shared constants, group codes and FSM state type for the interrupt request/ack sequencer.
package irq_pkg;

  localparam int NCH = 9;

  localparam logic [1:0] GRP_NONE = 2'd0;
  localparam logic [1:0] GRP_A    = 2'd1;
  localparam logic [1:0] GRP_B    = 2'd2;
  localparam logic [1:0] GRP_C    = 2'd3;

  localparam logic [3:0] CHAN_MAX = 4'(NCH - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, ACK} state_e;

  function automatic logic [NCH-1:0] chan_onehot(input logic [3:0] chan);
    logic [NCH-1:0] v;
    v = {{(NCH-1){1'b0}}, 1'b1} << chan;
    return v;
  endfunction

endpackage

// File: rtl/irq_ack_sequencer_pend_bank.sv
// One group's pending register: rising-edge capture of device requests with per-bit clear.
module irq_pend_bank
  import irq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req_i,
  input  logic [NCH-1:0] clr_i,
  output logic [NCH-1:0] pend_o
);

  logic [NCH-1:0] req_q;
  logic [NCH-1:0] pend_q;

  // Reset loads the live request level so a line held high across reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= req_i;
      pend_q <= '0;
    end else begin
      req_q  <= req_i;
      pend_q <= (pend_q & ~clr_i) | (req_i & ~req_q);
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/irq_ack_sequencer.sv
// Captures request edges, lets the external priority controller settle, presents the winning
// vector over valid/ready and acknowledges the served device.
module irq_ack_sequencer
  import irq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req_a,
  input  logic [NCH-1:0] req_b,
  input  logic [NCH-1:0] req_c,
  input  logic [NCH-1:0] en,
  output logic [NCH-1:0] ctl_e,
  output logic [NCH-1:0] ctl_a,
  output logic [NCH-1:0] ctl_b,
  output logic [NCH-1:0] ctl_c,
  input  logic           grant_pa,
  input  logic           grant_pb,
  input  logic           grant_pc,
  input  logic [3:0]     grant_chan,
  output logic           irq_valid,
  input  logic           irq_ready,
  output logic [1:0]     irq_grp,
  output logic [3:0]     irq_chan,
  output logic [NCH-1:0] ack_a,
  output logic [NCH-1:0] ack_b,
  output logic [NCH-1:0] ack_c,
  output logic           err
);

  state_e         state_q;
  logic           valid_q;
  logic [1:0]     grp_q;
  logic [3:0]     chan_q;
  logic [NCH-1:0] ack_a_q, ack_b_q, ack_c_q;
  logic           err_q;
  logic [1:0]     grant_grp_s;
  logic [NCH-1:0] pend_en_s;

  // Registered ack pulses double as the pending clears, landing on the closing edge of ACK.
  irq_pend_bank u_bank_a (.clk(clk), .rst(rst), .req_i(req_a), .clr_i(ack_a_q), .pend_o(ctl_a));
  irq_pend_bank u_bank_b (.clk(clk), .rst(rst), .req_i(req_b), .clr_i(ack_b_q), .pend_o(ctl_b));
  irq_pend_bank u_bank_c (.clk(clk), .rst(rst), .req_i(req_c), .clr_i(ack_c_q), .pend_o(ctl_c));

  assign ctl_e     = en;
  assign pend_en_s = (ctl_a | ctl_b | ctl_c) & en;

  always_comb begin
    if (grant_pa) begin
      grant_grp_s = GRP_A;
    end else if (grant_pb) begin
      grant_grp_s = GRP_B;
    end else if (grant_pc) begin
      grant_grp_s = GRP_C;
    end else begin
      grant_grp_s = GRP_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      grp_q   <= GRP_NONE;
      chan_q  <= 4'd0;
      ack_a_q <= '0;
      ack_b_q <= '0;
      ack_c_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ack_a_q <= '0;
      ack_b_q <= '0;
      ack_c_q <= '0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|pend_en_s) state_q <= SETTLE;
          else            state_q <= IDLE;
        end
        SETTLE: begin
          if (grant_grp_s == GRP_NONE) begin
            state_q <= IDLE;
          end else if (grant_chan > CHAN_MAX) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            grp_q   <= grant_grp_s;
            chan_q  <= grant_chan;
            valid_q <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ready) begin
            valid_q <= 1'b0;
            state_q <= ACK;
            case (grp_q)
              GRP_A:   ack_a_q <= chan_onehot(chan_q);
              GRP_B:   ack_b_q <= chan_onehot(chan_q);
              GRP_C:   ack_c_q <= chan_onehot(chan_q);
              default: ack_a_q <= '0;
            endcase
          end else begin
            state_q <= PRESENT;
          end
        end
        ACK: begin
          grp_q   <= GRP_NONE;
          chan_q  <= 4'd0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign irq_valid = valid_q;
  assign irq_grp   = grp_q;
  assign irq_chan  = chan_q;
  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign ack_c     = ack_c_q;
  assign err       = err_q;

endmodule
